pattern_sync_gen: RTL and testbench

Frame/line timing generator that sits directly upstream of the pattern generator. It produces the `f_sync` and `sync` pulses that pace the generator's lines and frames. It also drives the generator's configuration inputs (`Mode`, `constVal`, `X`, `Y`) from shadow registers, which are reloaded only at frame start so a frame never changes pattern midway. It supports single-shot and continuous frame runs, line lengths that depend on the pattern mode, and a synchronous abort.

---
 rtl/pattern_sync_gen.sv | 118 +++++++++++
 tb/tb_pattern_sync_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sync_gen.sv
// Frame/line timing generator feeding the pattern generator.
// Emits f_sync/sync line pacing pulses and holds the pattern configuration
// in shadow registers that reload only when a frame is launched.
module pattern_sync_gen #(
    parameter int LINE_PERIOD     = 1300,
    parameter int LONG_PERIOD     = 4100,
    parameter int LINES_PER_FRAME = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic        abort,
    input  logic [2:0]  mode_in,
    input  logic [11:0] const_in,
    input  logic [1:0]  x_in,
    input  logic [1:0]  y_in,
    output logic        f_sync,
    output logic        sync,
    output logic [2:0]  Mode,
    output logic [11:0] constVal,
    output logic [1:0]  X,
    output logic [1:0]  Y,
    output logic [4:0]  line_idx,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [0:0]  S_IDLE       = 1'b0;
    localparam logic [0:0]  S_RUN        = 1'b1;
    localparam logic [2:0]  MODE_REGULAR = 3'b001;
    localparam logic [12:0] LINE_LAST    = 13'(LINE_PERIOD - 1);
    localparam logic [12:0] LONG_LAST    = 13'(LONG_PERIOD - 1);
    localparam logic [4:0]  LAST_LINE    = 5'(LINES_PER_FRAME - 1);

    logic [0:0]  state;
    logic [12:0] pix_cnt;
    logic [4:0]  line_cnt;
    logic [12:0] pix_last;
    logic [12:0] pix_prelast;

    // Line period follows the latched mode only, never the requested one
    always_comb begin
        pix_last    = (Mode == MODE_REGULAR) ? LONG_LAST : LINE_LAST;
        pix_prelast = pix_last - 13'd1;
    end

    // frame_done is raised one edge early so it occupies the final cycle of
    // the frame; the back-to-back relaunch then lands on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            f_sync     <= 1'b0;
            sync       <= 1'b0;
            frame_done <= 1'b0;
            Mode       <= '0;
            constVal   <= '0;
            X          <= '0;
            Y          <= '0;
        end else if (abort) begin
            state      <= S_IDLE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            f_sync     <= 1'b0;
            sync       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            f_sync     <= 1'b0;
            sync       <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    pix_cnt  <= '0;
                    line_cnt <= '0;
                    if (start) begin
                        Mode     <= mode_in;
                        constVal <= const_in;
                        X        <= x_in;
                        Y        <= y_in;
                        f_sync   <= 1'b1;
                        sync     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                default: begin
                    if (pix_cnt < pix_last) begin
                        pix_cnt <= pix_cnt + 13'd1;
                        if ((pix_cnt == pix_prelast) && (line_cnt == LAST_LINE))
                            frame_done <= 1'b1;
                    end else if (line_cnt < LAST_LINE) begin
                        pix_cnt  <= '0;
                        line_cnt <= line_cnt + 5'd1;
                        sync     <= 1'b1;
                    end else begin
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        if (cont) begin
                            Mode     <= mode_in;
                            constVal <= const_in;
                            X        <= x_in;
                            Y        <= y_in;
                            f_sync   <= 1'b1;
                            sync     <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign line_idx = line_cnt;
    assign busy     = (state == S_RUN);

endmodule

// File: tb/tb_pattern_sync_gen.sv
// Self-checking bench for pattern_sync_gen using a frame-time reference model.
`timescale 1ns/1ps
module tb_pattern_sync_gen;

    localparam int LP = 20;
    localparam int GP = 37;
    localparam int NL = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, cont = 1'b0, abort = 1'b0;
    logic [2:0]  mode_in = '0;
    logic [11:0] const_in = '0;
    logic [1:0]  x_in = '0, y_in = '0;
    logic        f_sync, sync, busy, frame_done;
    logic [2:0]  Mode;
    logic [11:0] constVal;
    logic [1:0]  X, Y;
    logic [4:0]  line_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sync_q[$];
    int fs_q[$];
    int fd_q[$];

    pattern_sync_gen #(
        .LINE_PERIOD(LP),
        .LONG_PERIOD(GP),
        .LINES_PER_FRAME(NL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .mode_in(mode_in), .const_in(const_in), .x_in(x_in), .y_in(y_in),
        .f_sync(f_sync), .sync(sync), .Mode(Mode), .constVal(constVal),
        .X(X), .Y(Y), .line_idx(line_idx), .busy(busy), .frame_done(frame_done)
    );

    always #8 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: elapsed time since launch plus the latched config
    bit          m_run;
    int          m_t;
    logic [2:0]  m_mode;
    logic [11:0] m_const;
    logic [1:0]  m_x, m_y;

    function automatic int period(input logic [2:0] m);
        return (m == 3'b001) ? GP : LP;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_mode = '0; m_const = '0; m_x = '0; m_y = '0;
        end else if (abort) begin
            m_run = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_t = 0;
                m_mode = mode_in; m_const = const_in; m_x = x_in; m_y = y_in;
            end
        end else begin
            m_t++;
            if (m_t == NL * period(m_mode)) begin
                if (cont) begin
                    m_t = 0;
                    m_mode = mode_in; m_const = const_in; m_x = x_in; m_y = y_in;
                end else begin
                    m_run = 0;
                end
            end
        end
    end

    // Per-cycle comparison plus pulse timestamp capture
    always @(negedge clk) begin
        int p;
        p = period(m_mode);
        chk("f_sync",     f_sync,     (m_run && m_t == 0) ? 1 : 0);
        chk("sync",       sync,       (m_run && (m_t % p) == 0) ? 1 : 0);
        chk("frame_done", frame_done, (m_run && m_t == NL * p - 1) ? 1 : 0);
        chk("busy",       busy,       m_run ? 1 : 0);
        chk("line_idx",   line_idx,   m_run ? (m_t / p) : 0);
        chk("Mode",       Mode,       m_mode);
        chk("constVal",   constVal,   m_const);
        chk("X",          X,          m_x);
        chk("Y",          Y,          m_y);
        if (sync)       sync_q.push_back(cyc);
        if (f_sync)     fs_q.push_back(cyc);
        if (frame_done) fd_q.push_back(cyc);
    end

    task automatic clear_q();
        sync_q.delete(); fs_q.delete(); fd_q.delete();
    endtask

    task automatic launch(input logic [2:0] m, input logic [11:0] c, input logic cv, output int e);
        mode_in = m; const_in = c; x_in = 2'($urandom); y_in = 2'($urandom); cont = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = cyc;
    endtask

    task automatic wait_to(input int target);
        int guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < target) chk("wait_bound", cyc, target);
    endtask

    initial begin
        int e;
        // Reset and idle
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_sync_count", sync_q.size(), 0);

        // Single frame, non-REGULAR mode
        clear_q();
        launch(3'b010, 12'hABC, 1'b0, e);
        chk("launch_fsync", f_sync, 1);
        chk("launch_const", constVal, 12'hABC);
        wait_to(e + NL * LP + 5);
        chk("single_nsync", sync_q.size(), 6);
        if (sync_q.size() == 6) begin
            chk("single_spacing", sync_q[1] - sync_q[0], 20);
            chk("single_last_sync", sync_q[5] - sync_q[0], 100);
        end
        chk("single_nfd", fd_q.size(), 1);
        if (fd_q.size() == 1) chk("single_fd_time", fd_q[0] - e, 119);
        chk("single_busy_end", busy, 0);

        // REGULAR mode; requested mode changes mid-frame
        clear_q();
        launch(3'b001, 12'h055, 1'b0, e);
        wait_to(e + 50);
        mode_in = 3'b111;
        wait_to(e + NL * GP + 5);
        chk("reg_nsync", sync_q.size(), 6);
        if (sync_q.size() == 6) chk("reg_spacing", sync_q[3] - sync_q[2], 37);
        if (fd_q.size() == 1) chk("reg_fd_time", fd_q[0] - e, 221);
        chk("reg_mode_held", Mode, 3'b001);

        // Continuous mode with mode change during frame 1
        clear_q();
        launch(3'b010, 12'h321, 1'b1, e);
        wait_to(e + 40);
        mode_in = 3'b001;
        wait_to(e + NL * LP + 100);
        cont = 1'b0;
        wait_to(e + NL * LP + NL * GP + 10);
        chk("cont_nfs", fs_q.size(), 2);
        chk("cont_nfd", fd_q.size(), 2);
        if (fs_q.size() == 2 && fd_q.size() == 2) begin
            chk("cont_no_gap", fs_q[1] - fd_q[0], 1);
            chk("cont_frame1_len", fs_q[1] - fs_q[0], 120);
            chk("cont_frame2_fd", fd_q[1] - fs_q[1], 221);
        end
        if (sync_q.size() >= 8) chk("cont_new_spacing", sync_q[7] - sync_q[6], 37);
        chk("cont_mode", Mode, 3'b001);

        // Abort mid-frame
        clear_q();
        launch(3'b010, 12'h0F0, 1'b0, e);
        wait_to(e + 3 * LP + 10 - 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        repeat (50) @(negedge clk);
        chk("abort_nsync", sync_q.size(), 4);
        chk("abort_nfd", fd_q.size(), 0);

        // Abort together with start in IDLE
        clear_q();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        repeat (30) @(negedge clk);
        chk("abort_start_nsync", sync_q.size(), 0);

        // Abort on the edge that would raise frame_done
        clear_q();
        launch(3'b010, 12'h777, 1'b0, e);
        wait_to(e + NL * LP - 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_end_nfd", fd_q.size(), 0);

        // start during RUN is ignored
        clear_q();
        launch(3'b010, 12'h123, 1'b0, e);
        wait_to(e + 30);
        mode_in = 3'b101; const_in = 12'hFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(e + NL * LP + 5);
        chk("rerun_nsync", sync_q.size(), 6);
        if (sync_q.size() == 6) chk("rerun_spacing", sync_q[2] - sync_q[1], 20);
        if (fd_q.size() == 1) chk("rerun_fd_time", fd_q[0] - e, 119);
        chk("rerun_const", constVal, 12'h123);
        chk("rerun_mode", Mode, 3'b010);

        // Asynchronous reset mid-frame
        launch(3'b001, 12'hDEF, 1'b0, e);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_const", constVal, 0);
        chk("areset_line", line_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 9) == 0);
            abort    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) cont = ~cont;
            mode_in  = ($urandom_range(0, 2) == 0) ? 3'b001 : 3'($urandom);
            const_in = 12'($urandom);
            x_in     = 2'($urandom);
            y_in     = 2'($urandom);
        end
        start = 1'b0; abort = 1'b0; cont = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
